// File: rtl/frame_pkg.sv
// Shared framing definitions for the sample link: frame layout, byte indices, FSM states.
// The receive-side deframer reuses this package, so the layout lives here only.
package frame_pkg;

  localparam int         FRAME_LEN    = 6;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [2:0] IDX_SYNC = 3'd0;
  localparam logic [2:0] IDX_I_HI = 3'd1;
  localparam logic [2:0] IDX_I_LO = 3'd2;
  localparam logic [2:0] IDX_U_HI = 3'd3;
  localparam logic [2:0] IDX_U_LO = 3'd4;
  localparam logic [2:0] IDX_CHK  = 3'(FRAME_LEN - 1);

  function automatic logic [7:0] frame_chk(input logic [15:0] i, input logic [15:0] u);
    return i[15:8] ^ i[7:0] ^ u[15:8] ^ u[7:0];
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [7:0]  sync,
                                            input logic [15:0] i,
                                            input logic [15:0] u,
                                            input logic [7:0]  chk);
    logic [7:0] b;
    b = sync;
    case (idx)
      IDX_I_HI: b = i[15:8];
      IDX_I_LO: b = i[7:0];
      IDX_U_HI: b = u[15:8];
      IDX_U_LO: b = u[7:0];
      IDX_CHK:  b = chk;
      default:  b = sync;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sample_framer.sv
// Packs one I/U sample pair into a 6-byte checksummed frame and streams it byte-wise.
// Latency: SYNC byte valid one cycle after the word_clk rising edge; 1 byte/cycle max.
// Backpressure: tx_data/tx_valid held until tx_ready; strobes arriving mid-frame are dropped and counted.
module sample_framer
  import frame_pkg::*;
#(
  parameter int         WIDTH     = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_clk,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] data_u,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic [7:0]       overrun_cnt
);

  logic        wc_q;
  logic        new_sample;
  logic [15:0] ext_i;
  logic [15:0] ext_u;
  state_t      state;
  logic [2:0]  idx;
  logic [15:0] snap_i;
  logic [15:0] snap_u;
  logic [7:0]  snap_chk;

  // word_clk is generated from clk, so a single register suffices for edge detection.
  assign new_sample = word_clk & ~wc_q;
  assign ext_i      = 16'($signed(data_i));
  assign ext_u      = 16'($signed(data_u));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc_q        <= 1'b0;
      state       <= IDLE;
      idx         <= IDX_SYNC;
      snap_i      <= 16'h0000;
      snap_u      <= 16'h0000;
      snap_chk    <= 8'h00;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      overrun_cnt <= 8'h00;
    end else begin
      wc_q <= word_clk;
      case (state)
        IDLE: begin
          if (new_sample) begin
            snap_i   <= ext_i;
            snap_u   <= ext_u;
            snap_chk <= frame_chk(ext_i, ext_u);
            idx      <= IDX_SYNC;
            tx_data  <= SYNC_BYTE;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          // A strobe during a frame, including its last-transfer cycle, is an overrun.
          if (new_sample && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
          if (tx_ready) begin
            if (idx == IDX_CHK) begin
              idx      <= IDX_SYNC;
              tx_data  <= 8'h00;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              idx     <= idx + 3'd1;
              tx_data <= frame_byte(idx + 3'd1, SYNC_BYTE, snap_i, snap_u, snap_chk);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_framer.sv
// Randomized scoreboard bench for sample_framer, plus a WIDTH=12 packing check.
module tb_sample_framer;
  import frame_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        word_clk = 1'b0;
  logic [15:0] data_i = '0;
  logic [15:0] data_u = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic [7:0]  overrun_cnt;

  logic        wc12 = 1'b0;
  logic [11:0] di12 = '0;
  logic [11:0] du12 = '0;
  logic [7:0]  tx_data12;
  logic        tx_valid12;
  logic        tx_ready12 = 1'b1;
  logic        busy12;
  logic [7:0]  ovr12;

  always #5 clk = ~clk;

  sample_framer #(.WIDTH(16), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .word_clk(word_clk), .data_i(data_i), .data_u(data_u),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .overrun_cnt(overrun_cnt));

  sample_framer #(.WIDTH(12), .SYNC_BYTE(8'hA5)) dut12 (
    .clk(clk), .rst_n(rst_n), .word_clk(wc12), .data_i(di12), .data_u(du12),
    .tx_data(tx_data12), .tx_valid(tx_valid12), .tx_ready(tx_ready12), .busy(busy12),
    .overrun_cnt(ovr12));

  int tests = 0;
  int fails = 0;

  // Reference model: frame occupancy, overrun count and pending bytes, from input history only.
  logic [7:0] exp_q[$];
  int         rem = 0;
  int         ovr_m = 0;
  logic       prev_wc = 1'b0;
  logic       exp_valid = 1'b0;
  int         exp_ovr = 0;
  logic       chk_en = 1'b0;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_dat = '0;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic push_frame(input logic [15:0] i, input logic [15:0] u);
    exp_q.push_back(8'hA5);
    exp_q.push_back(i[15:8]);
    exp_q.push_back(i[7:0]);
    exp_q.push_back(u[15:8]);
    exp_q.push_back(u[7:0]);
    exp_q.push_back(i[15:8] ^ i[7:0] ^ u[15:8] ^ u[7:0]);
  endtask

  task automatic step(input logic wc, input logic rdy, input logic [15:0] di, input logic [15:0] du);
    logic sample;
    @(posedge clk);
    #1;
    word_clk = wc; tx_ready = rdy; data_i = di; data_u = du;
    exp_valid = (rem > 0);
    exp_ovr   = ovr_m;
    sample    = wc & ~prev_wc;
    prev_wc   = wc;
    if (rem > 0) begin
      if (sample) ovr_m = (ovr_m == 255) ? 255 : ovr_m + 1;
      if (rdy) rem--;
    end else if (sample) begin
      push_frame(di, du);
      rem = FRAME_LEN;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && rem > 0; k++) step(1'b0, 1'b1, 16'h0, 16'h0);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    if (rem != 0) chk("drain_timeout", 16'(rem), 16'h0);
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("tx_valid", 16'(tx_valid), 16'(exp_valid));
      chk("busy", 16'(busy), 16'(exp_valid));
      chk("overrun_cnt", 16'(overrun_cnt), 16'(exp_ovr));
      if (exp_valid) begin
        if (hold_prev) chk("hold_stable", 16'(tx_data), 16'(hold_dat));
        if (tx_ready) begin
          if (exp_q.size() == 0) chk("queue_empty", 16'(tx_data), 16'hFFFF);
          else chk("tx_data", 16'(tx_data), 16'(exp_q.pop_front()));
        end
      end
      hold_prev = exp_valid && !tx_ready;
      hold_dat  = tx_data;
    end
  end

  logic [7:0] exp12 [6] = '{8'hA5, 8'hF8, 8'h00, 8'h07, 8'hFF, 8'h00};
  logic [15:0] ri, ru;
  logic        rwc;
  logic [1:0]  tog [4] = '{2'd1, 2'd0, 2'd0, 2'd1};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 16'(tx_valid), 16'h0);
    chk("reset_data", 16'(tx_data), 16'h0);
    chk("reset_ovr", 16'(overrun_cnt), 16'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // WIDTH=12 sign extension and checksum.
    @(posedge clk);
    #1;
    di12 = 12'h800; du12 = 12'h7FF; wc12 = 1'b1;
    @(negedge clk);
    chk("w12_idle", 16'(tx_valid12), 16'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("w12_valid", 16'(tx_valid12), 16'h1);
      chk("w12_byte", 16'(tx_data12), 16'(exp12[k]));
    end
    @(negedge clk);
    chk("w12_end", 16'(busy12), 16'h0);
    wc12 = 1'b0;

    // Single frame, ready held high.
    step(1'b1, 1'b1, 16'h1234, 16'hFEDC);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 16'h0, 16'h0);

    // Ready toggled 1-0-0-1.
    step(1'b1, 1'b1, 16'hA55A, 16'h0F0F);
    for (int k = 0; k < 30; k++) step(1'b0, tog[k % 4][0], 16'h0, 16'h0);
    drain();

    // Overrun mid-frame and at the last-transfer cycle, then the next strobe is accepted.
    step(1'b1, 1'b1, 16'h0102, 16'h0304);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    step(1'b1, 1'b1, 16'hDEAD, 16'hBEEF);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    step(1'b1, 1'b1, 16'hCAFE, 16'hF00D);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    step(1'b1, 1'b1, 16'h7777, 16'h8888);
    drain();
    @(negedge clk);
    chk("ovr_two", 16'(overrun_cnt), 16'h2);

    // Saturation: frame stalled by ready=0 while 300 more strobes arrive.
    step(1'b1, 1'b0, 16'h5555, 16'hAAAA);
    for (int k = 0; k < 300; k++) begin
      step(1'b0, 1'b0, 16'h0, 16'h0);
      step(1'b1, 1'b0, 16'h1111, 16'h2222);
    end
    step(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("ovr_sat", 16'(overrun_cnt), 16'hFF);
    drain();

    // Reset pulsed at byte index 3.
    step(1'b1, 1'b1, 16'h4321, 16'h8765);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    chk("pre_reset_byte3", 16'(tx_data), 16'h87);
    rst_n = 1'b0;
    exp_q.delete(); rem = 0; ovr_m = 0; prev_wc = 1'b0;
    exp_valid = 1'b0; exp_ovr = 0; hold_prev = 1'b0;
    word_clk = 1'b0;
    #1;
    chk("rst_valid", 16'(tx_valid), 16'h0);
    chk("rst_ovr", 16'(overrun_cnt), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    #2;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 16'h9ABC, 16'h0123);
    drain();

    // word_clk held high: a single frame only.
    for (int k = 0; k < 40; k++) step(1'b1, 1'b1, 16'h6006, 16'h9009);
    step(1'b0, 1'b1, 16'h0, 16'h0);
    drain();

    // Randomized traffic.
    rwc = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) rwc = ~rwc;
      ri = 16'($urandom);
      ru = 16'($urandom);
      step(rwc, ($urandom_range(0, 9) < 7), ri, ru);
    end
    drain();

    chk("final_queue", 16'(exp_q.size()), 16'h0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
